// File: rtl/id_stage_reg.sv
// Decode stage: control decode, condition check, register file and ID/EX pipeline register.
// Define ID_WB_BYPASS_EN to forward a same-cycle WB write onto the read ports.
module id_stage_reg #(
  parameter int unsigned       DATA_W       = 32,
  parameter int unsigned       REG_CNT      = 16,
  parameter logic [DATA_W-1:0] RF_RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              wb_en,
  input  logic [3:0]        wb_dest,
  input  logic [DATA_W-1:0] wb_value,
  input  logic [3:0]        sr,
  input  logic              hazard,
  input  logic              stall,
  input  logic              flush,
  output logic [3:0]        src1,
  output logic [3:0]        src2,
  output logic              two_src,
  output logic              ex_valid,
  output logic              ex_wb_en,
  output logic              ex_mem_r_en,
  output logic              ex_mem_w_en,
  output logic              ex_b,
  output logic              ex_s,
  output logic              ex_imm,
  output logic [3:0]        ex_exe_cmd,
  output logic [DATA_W-1:0] ex_val_rn,
  output logic [DATA_W-1:0] ex_val_rm,
  output logic [DATA_W-1:0] ex_pc,
  output logic [11:0]       ex_shift_operand,
  output logic [23:0]       ex_signed_imm_24,
  output logic [3:0]        ex_dest,
  output logic [3:0]        ex_src1,
  output logic [3:0]        ex_src2
);

  logic [3:0] cond, opcode, rn, rd;
  logic [1:0] mode;
  logic       i_bit, s_bit;

  assign cond   = instr[31:28];
  assign mode   = instr[27:26];
  assign i_bit  = instr[25];
  assign opcode = instr[24:21];
  assign s_bit  = instr[20];
  assign rn     = instr[19:16];
  assign rd     = instr[15:12];

  // Ungated control unit outputs
  logic       cu_wb_en, cu_mem_r_en, cu_mem_w_en, cu_b, cu_s;
  logic [3:0] cu_exe_cmd;

  always_comb begin
    cu_wb_en    = 1'b0;
    cu_mem_r_en = 1'b0;
    cu_mem_w_en = 1'b0;
    cu_b        = 1'b0;
    cu_s        = 1'b0;
    cu_exe_cmd  = 4'b0000;
    unique case (mode)
      2'b00: begin
        cu_s = s_bit;
        case (opcode)
          4'b1101: begin cu_exe_cmd = 4'b0001; cu_wb_en = 1'b1; end // MOV
          4'b1111: begin cu_exe_cmd = 4'b1001; cu_wb_en = 1'b1; end // MVN
          4'b0100: begin cu_exe_cmd = 4'b0010; cu_wb_en = 1'b1; end // ADD
          4'b0101: begin cu_exe_cmd = 4'b0011; cu_wb_en = 1'b1; end // ADC
          4'b0010: begin cu_exe_cmd = 4'b0100; cu_wb_en = 1'b1; end // SUB
          4'b0110: begin cu_exe_cmd = 4'b0101; cu_wb_en = 1'b1; end // SBC
          4'b0000: begin cu_exe_cmd = 4'b0110; cu_wb_en = 1'b1; end // AND
          4'b1100: begin cu_exe_cmd = 4'b0111; cu_wb_en = 1'b1; end // ORR
          4'b0001: begin cu_exe_cmd = 4'b1000; cu_wb_en = 1'b1; end // EOR
          4'b1010: cu_exe_cmd = 4'b0100;                            // CMP
          4'b1000: cu_exe_cmd = 4'b0110;                            // TST
          default: cu_s = 1'b0;
        endcase
      end
      2'b01: begin
        cu_exe_cmd  = 4'b0010;
        cu_mem_r_en = s_bit;
        cu_wb_en    = s_bit;
        cu_mem_w_en = ~s_bit;
      end
      2'b10:   cu_b = 1'b1;
      default: ;
    endcase
  end

  logic n_f, z_f, c_f, v_f, cond_pass;
  assign {n_f, z_f, c_f, v_f} = sr;

  always_comb begin
    unique case (cond)
      4'b0000: cond_pass = z_f;
      4'b0001: cond_pass = ~z_f;
      4'b0010: cond_pass = c_f;
      4'b0011: cond_pass = ~c_f;
      4'b0100: cond_pass = n_f;
      4'b0101: cond_pass = ~n_f;
      4'b0110: cond_pass = v_f;
      4'b0111: cond_pass = ~v_f;
      4'b1000: cond_pass = c_f & ~z_f;
      4'b1001: cond_pass = ~c_f | z_f;
      4'b1010: cond_pass = (n_f == v_f);
      4'b1011: cond_pass = (n_f != v_f);
      4'b1100: cond_pass = ~z_f & (n_f == v_f);
      4'b1101: cond_pass = z_f | (n_f != v_f);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  assign src1    = rn;
  assign src2    = cu_mem_w_en ? rd : instr[3:0];
  assign two_src = ~i_bit | cu_mem_w_en;

  logic kill;
  assign kill = hazard | ~cond_pass | ~instr_valid;

  // Register file
  logic [DATA_W-1:0] rf_q [REG_CNT];
  logic              wb_ok, rd1_ok, rd2_ok;
  logic [DATA_W-1:0] val_rn, val_rm;

  assign wb_ok  = wb_en && (32'(wb_dest) < REG_CNT);
  assign rd1_ok = 32'(src1) < REG_CNT;
  assign rd2_ok = 32'(src2) < REG_CNT;

  always_comb begin
    val_rn = rd1_ok ? rf_q[src1] : '0;
    val_rm = rd2_ok ? rf_q[src2] : '0;
`ifdef ID_WB_BYPASS_EN
    if (wb_ok && wb_dest == src1) val_rn = wb_value;
    if (wb_ok && wb_dest == src2) val_rm = wb_value;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < REG_CNT; i++) rf_q[i] <= RF_RESET_VAL;
    end else if (wb_ok) begin
      rf_q[wb_dest] <= wb_value;
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      ex_valid         <= 1'b0;
      ex_wb_en         <= 1'b0;
      ex_mem_r_en      <= 1'b0;
      ex_mem_w_en      <= 1'b0;
      ex_b             <= 1'b0;
      ex_s             <= 1'b0;
      ex_imm           <= 1'b0;
      ex_exe_cmd       <= '0;
      ex_val_rn        <= '0;
      ex_val_rm        <= '0;
      ex_pc            <= '0;
      ex_shift_operand <= '0;
      ex_signed_imm_24 <= '0;
      ex_dest          <= '0;
      ex_src1          <= '0;
      ex_src2          <= '0;
    end else if (!stall) begin
      ex_valid         <= ~kill;
      ex_wb_en         <= cu_wb_en & ~kill;
      ex_mem_r_en      <= cu_mem_r_en & ~kill;
      ex_mem_w_en      <= cu_mem_w_en & ~kill;
      ex_b             <= cu_b & ~kill;
      ex_s             <= cu_s & ~kill;
      ex_imm           <= i_bit;
      ex_exe_cmd       <= kill ? 4'b0000 : cu_exe_cmd;
      ex_val_rn        <= val_rn;
      ex_val_rm        <= val_rm;
      ex_pc            <= pc_in;
      ex_shift_operand <= instr[11:0];
      ex_signed_imm_24 <= instr[23:0];
      ex_dest          <= rd;
      ex_src1          <= src1;
      ex_src2          <= src2;
    end
  end

endmodule
